// File: rtl/fpga_robots_game_serial_rx_pkg.sv
// Shared definitions for the serial console receiver: FSM states, the
// oversampling constants and the majority-vote helper.
package fpga_robots_game_serial_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int unsigned OVERSAMPLE = 8;
  localparam logic [2:0]  SAMPLE_A   = 3'd3;
  localparam logic [2:0]  SAMPLE_B   = 3'd4;
  localparam logic [2:0]  SAMPLE_C   = 3'd5;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/fpga_robots_game_serial_rx_if.sv
// Receive-side holding register handshake between the UART receiver and
// the command/keyboard consumer.
interface fpga_robots_game_serial_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_overrun;
  logic       rx_ferr;
  logic       rx_busy;

  modport master (
    output rx_data, rx_valid, rx_overrun, rx_ferr, rx_busy,
    input  rx_ack
  );

  modport slave (
    input  rx_data, rx_valid, rx_overrun, rx_ferr, rx_busy,
    output rx_ack
  );
endinterface

// File: rtl/fpga_robots_game_serial_rx_sync.sv
// Multi-flop synchronizer for asynchronous input pins; resets to the idle
// line level so a reset never looks like a start bit or clock edge.
module fpga_robots_game_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/fpga_robots_game_serial_rx.sv
// 8N1 UART receiver: 8x oversampled, majority-voted mid-bit sampling, with a
// one-entry holding register and valid/ack handshake.
module fpga_robots_game_serial_rx
  import fpga_robots_game_serial_rx_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LEVEL  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud8,
  input  logic                          rxd,
  fpga_robots_game_serial_rx_if.master  rx
);

  logic       rxd_s;
  logic       line;
  rx_state_t  state;
  logic [2:0] tick;
  logic [2:0] tick_next;
  logic [1:0] votes;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic [7:0] data_q;
  logic       valid_q;
  logic       ovr_q;
  logic       ferr_q;
  logic       busy_q;
  logic       bit_val;
  logic       decide;
  logic       wrap;
  logic       deliver;

  fpga_robots_game_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_LEVEL  (IDLE_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  // line=1 means mark, independent of the pin polarity
  assign line = (rxd_s == IDLE_LEVEL);

  always_comb begin
    tick_next = tick + 3'd1;
    bit_val   = maj3(votes[0], votes[1], line);
    decide    = baud8 && (state == START || state == DATA || state == STOP)
                && (tick_next == SAMPLE_C);
    wrap      = (tick == 3'(OVERSAMPLE - 1));
    deliver   = decide && (state == STOP) && bit_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tick    <= '0;
      votes   <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;

      if (baud8) begin
        if (state != IDLE) begin
          tick <= tick_next;
          if (tick_next == SAMPLE_A) votes[0] <= line;
          if (tick_next == SAMPLE_B) votes[1] <= line;
        end

        case (state)
          IDLE: begin
            if (!line) begin
              state  <= START;
              tick   <= '0;
              busy_q <= 1'b1;
            end
          end
          START: begin
            if (decide && bit_val) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else if (wrap) begin
              state  <= DATA;
              bitcnt <= '0;
            end
          end
          DATA: begin
            if (decide) shreg <= {bit_val, shreg[7:1]};
            if (wrap) begin
              if (bitcnt == 3'd7) state <= STOP;
              else                bitcnt <= bitcnt + 3'd1;
            end
          end
          STOP: begin
            // Leave at the stop-bit decision, not the wrap, so back-to-back
            // frames can start detecting in the second half of the stop bit.
            if (decide) begin
              if (bit_val) begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end else begin
                state  <= BREAK;
                ferr_q <= 1'b1;
              end
            end
          end
          BREAK: begin
            if (line) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end

      if (deliver) begin
        if (!valid_q || rx.rx_ack) begin
          data_q  <= shreg;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (rx.rx_ack && valid_q) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx.rx_data    = data_q;
  assign rx.rx_valid   = valid_q;
  assign rx.rx_overrun = ovr_q;
  assign rx.rx_ferr    = ferr_q;
  assign rx.rx_busy    = busy_q;

endmodule

// File: tb/tb_fpga_robots_game_serial_rx.sv
// Bench for the serial console receiver: frame-level timeline model checked
// every cycle, plus literal checks on received bytes and flag counts.
module tb_fpga_robots_game_serial_rx;

  localparam int SYNC = 2;
  localparam int DLY  = 77 * 8;

  localparam int K_ON   = 0;
  localparam int K_OFF  = 1;
  localparam int K_DLV  = 2;
  localparam int K_FERR = 3;

  typedef struct {
    int         t;
    int         k;
    logic [7:0] d;
  } ev_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic baud8 = 1'b0;
  logic rxd   = 1'b1;

  fpga_robots_game_serial_rx_if rx_if ();

  fpga_robots_game_serial_rx #(
    .SYNC_STAGES (SYNC),
    .IDLE_LEVEL  (1'b1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .baud8 (baud8),
    .rxd   (rxd),
    .rx    (rx_if)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   ack_at = -1;
  ev_t  evq[$];

  logic       m_valid = 1'b0;
  logic       m_busy  = 1'b0;
  logic       m_ovr   = 1'b0;
  logic       m_ferr  = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       dl;
  logic [7:0] db;

  int   ferr_cnt = 0;
  int   ovr_cnt = 0;
  int   first_rise = -1;
  logic prev_valid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int ceil8(input int x);
    return ((x + 7) / 8) * 8;
  endfunction

  task automatic add_ev(input int t, input int k, input logic [7:0] d);
    ev_t e;
    e.t = t;
    e.k = k;
    e.d = d;
    evq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_ack();
    ack_at = cyc + 3;
    idle(6);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // baud8 seen by the DUT on every posedge whose index is a multiple of 8
  initial forever begin
    @(negedge clk);
    baud8 = ((cyc + 1) % 8 == 0);
  end

  initial begin
    rx_if.rx_ack = 1'b0;
    forever begin
      @(negedge clk);
      rx_if.rx_ack = (cyc + 1 == ack_at);
    end
  end

  // Model: frame-level events on a clock timeline, applied with the
  // holding-register rules, compared against the DUT every cycle.
  initial forever begin
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 1'b0;
      m_busy  = 1'b0;
      m_ovr   = 1'b0;
      m_ferr  = 1'b0;
      m_data  = 8'h00;
      evq.delete();
    end else begin
      dl     = 1'b0;
      db     = 8'h00;
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      foreach (evq[i]) begin
        if (evq[i].t == cyc) begin
          case (evq[i].k)
            K_ON:    m_busy = 1'b1;
            K_OFF:   m_busy = 1'b0;
            K_DLV:   begin dl = 1'b1; db = evq[i].d; end
            default: m_ferr = 1'b1;
          endcase
        end
      end
      if (dl) begin
        if (!m_valid || rx_if.rx_ack) begin
          m_data  = db;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (rx_if.rx_ack && m_valid) begin
        m_valid = 1'b0;
      end
    end
    if (rx_if.rx_ferr) ferr_cnt++;
    if (rx_if.rx_overrun) ovr_cnt++;
    if (rx_if.rx_valid && !prev_valid && first_rise < 0) first_rise = cyc;
    prev_valid = rx_if.rx_valid;
    chk("valid", 32'(rx_if.rx_valid), 32'(m_valid));
    chk("data", 32'(rx_if.rx_data), 32'(m_data));
    chk("busy", 32'(rx_if.rx_busy), 32'(m_busy));
    chk("overrun", 32'(rx_if.rx_overrun), 32'(m_ovr));
    chk("ferr", 32'(rx_if.rx_ferr), 32'(m_ferr));
  end

  // Drives one frame starting at the next posedge; 64 clk per bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit noisy,
                            input bit ack_end, input bit hold_low, input int abort_t,
                            output int det);
    int   f;
    int   e;
    int   idx;
    logic lvl;
    bit   aborted;
    f   = cyc + 1;
    det = ceil8(f + SYNC);
    e   = det + DLY;
    add_ev(det, K_ON, 8'h00);
    if (stop_bit) begin
      add_ev(e, K_DLV, b);
      add_ev(e, K_OFF, 8'h00);
    end else begin
      add_ev(e, K_FERR, 8'h00);
    end
    if (ack_end) ack_at = e;
    aborted = 1'b0;
    for (int t = 0; t < 640 && !aborted; t++) begin
      if (t == abort_t) begin
        rst = 1'b1;
        #2;
        chk("rst_valid", 32'(rx_if.rx_valid), 32'd0);
        chk("rst_data", 32'(rx_if.rx_data), 32'h00);
        chk("rst_busy", 32'(rx_if.rx_busy), 32'd0);
        chk("rst_overrun", 32'(rx_if.rx_overrun), 32'd0);
        chk("rst_ferr", 32'(rx_if.rx_ferr), 32'd0);
        evq.delete();
        ack_at  = -1;
        aborted = 1'b1;
        @(negedge clk);
      end else begin
        idx = t / 64;
        if (idx == 0)      lvl = 1'b0;
        else if (idx <= 8) lvl = b[idx-1];
        else               lvl = stop_bit;
        // one-clock glitch that lands exactly on the tick-4 sample
        if (noisy && t == det - f + 64 * idx + 30) lvl = ~lvl;
        rxd = lvl;
        @(negedge clk);
      end
    end
    if (!hold_low || aborted) rxd = 1'b1;
  endtask

  int det;
  int f;
  int h;

  initial begin
    idle(5);
    chk("reset_valid", 32'(rx_if.rx_valid), 32'd0);
    chk("reset_data", 32'(rx_if.rx_data), 32'h00);
    chk("reset_busy", 32'(rx_if.rx_busy), 32'd0);
    rst = 1'b0;
    idle(20);

    do_ack();
    chk("ack_empty", 32'(rx_if.rx_valid), 32'd0);

    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, -1, det);
    chk("byte_55", 32'(rx_if.rx_data), 32'h55);
    chk("latency", 32'(first_rise - det), 32'd616);
    do_ack();
    chk("ack_clears", 32'(rx_if.rx_valid), 32'd0);
    chk("ack_keeps_data", 32'(rx_if.rx_data), 32'h55);

    send_frame(8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, -1, det);
    chk("byte_a3", 32'(rx_if.rx_data), 32'hA3);
    do_ack();
    idle(20);

    rxd = 1'b0;
    f   = cyc + 1;
    det = ceil8(f + SYNC);
    add_ev(det, K_ON, 8'h00);
    add_ev(det + 40, K_OFF, 8'h00);
    idle(16);
    rxd = 1'b1;
    idle(100);
    chk("glitch_busy", 32'(rx_if.rx_busy), 32'd0);
    chk("glitch_valid", 32'(rx_if.rx_valid), 32'd0);

    send_frame(8'h0F, 1'b1, 1'b1, 1'b0, 1'b0, -1, det);
    chk("byte_0f_noisy", 32'(rx_if.rx_data), 32'h0F);
    do_ack();
    idle(20);

    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, -1, det);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, -1, det);
    chk("overrun_keeps", 32'(rx_if.rx_data), 32'h11);
    chk("overrun_count", 32'(ovr_cnt), 32'd1);
    send_frame(8'h33, 1'b1, 1'b0, 1'b1, 1'b0, -1, det);
    chk("ack_with_delivery", 32'(rx_if.rx_data), 32'h33);
    chk("ack_with_delivery_valid", 32'(rx_if.rx_valid), 32'd1);
    chk("overrun_count2", 32'(ovr_cnt), 32'd1);
    do_ack();
    idle(20);

    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, -1, det);
    idle(20 * 64);
    chk("ferr_count", 32'(ferr_cnt), 32'd1);
    chk("break_busy", 32'(rx_if.rx_busy), 32'd1);
    chk("break_valid", 32'(rx_if.rx_valid), 32'd0);
    rxd = 1'b1;
    h   = cyc + 1;
    add_ev(ceil8(h + SYNC), K_OFF, 8'h00);
    idle(40);
    chk("break_exit", 32'(rx_if.rx_busy), 32'd0);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, -1, det);
    chk("byte_7e", 32'(rx_if.rx_data), 32'h7E);
    idle(20);

    send_frame(8'hB6, 1'b1, 1'b0, 1'b0, 1'b0, 64 * 5 + 10, det);
    idle(3);
    rst = 1'b0;
    idle(20);
    chk("post_reset_valid", 32'(rx_if.rx_valid), 32'd0);
    send_frame(8'hC9, 1'b1, 1'b0, 1'b0, 1'b0, -1, det);
    chk("byte_c9", 32'(rx_if.rx_data), 32'hC9);
    chk("byte_c9_valid", 32'(rx_if.rx_valid), 32'd1);
    do_ack();
    idle(10);
    chk("final_valid", 32'(rx_if.rx_valid), 32'd0);
    chk("final_ferr_count", 32'(ferr_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
